// File: rtl/npu_act_pkg.sv
// npu_act_pkg: activation mode encodings and shared constants for the requantize stage
package npu_act_pkg;
    typedef enum logic [1:0] {
        ACT_SAT   = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLAMP = 2'd3
    } act_mode_e;
    localparam int LEAKY_SHIFT   = 3;
    localparam int SAT_CNT_WIDTH = 16;
endpackage

// File: rtl/act_lane.sv
// act_lane: one lane of rounding right-shift, activation and saturation
module act_lane
    import npu_act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   ld1_i,
    input  logic                   ld2_i,
    input  logic [ACC_WIDTH-1:0]   x_i,
    input  logic [SHIFT_WIDTH-1:0] shift_i,
    input  logic [1:0]             mode_i,
    input  logic [DATA_WIDTH-1:0]  clip_i,
    output logic [DATA_WIDTH-1:0]  y_o,
    output logic                   sat_o,
    output logic                   sat_d_o
);
    localparam int AW = ACC_WIDTH;
    localparam logic signed [AW:0] MAXV = (AW+1)'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [AW:0] MINV = ~MAXV;

    logic signed [AW:0] xe, rnd, sh_r, r_d, r_q, lk, c, relu, a;
    logic sat_hi, sat_lo;
    logic [DATA_WIDTH-1:0] y_d, y_q;
    logic sat_q;

    // one extra bit of headroom keeps x + rounding term from overflowing
    always_comb begin
        xe      = $signed({x_i[AW-1], x_i});
        rnd     = (shift_i == '0) ? '0 : (AW+1)'(1) << (shift_i - 1'b1);
        sh_r    = (xe + rnd) >>> shift_i;
        r_d     = (32'(shift_i) >= AW) ? $signed({(AW+1){x_i[AW-1]}}) : sh_r;
        lk      = r_q >>> LEAKY_SHIFT;
        c       = clip_i[DATA_WIDTH-1] ? '0 : (AW+1)'($signed(clip_i));
        relu    = r_q[AW] ? '0 : r_q;
        a       = (mode_i == ACT_SAT)   ? r_q :
                  (mode_i == ACT_RELU)  ? relu :
                  (mode_i == ACT_LEAKY) ? (r_q[AW] ? lk : r_q) :
                  (relu > c ? c : relu);
        sat_hi  = a > MAXV;
        sat_lo  = a < MINV;
        y_d     = sat_hi ? MAXV[DATA_WIDTH-1:0] : sat_lo ? MINV[DATA_WIDTH-1:0] : a[DATA_WIDTH-1:0];
        sat_d_o = sat_hi | sat_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            y_q   <= '0;
            sat_q <= 1'b0;
        end else begin
            if (ld1_i) r_q <= r_d;
            if (clear) begin
                y_q   <= '0;
                sat_q <= 1'b0;
            end else if (ld2_i) begin
                y_q   <= y_d;
                sat_q <= sat_d_o;
            end
        end
    end

    assign y_o   = y_q;
    assign sat_o = sat_q;
endmodule

// File: rtl/act_quant_unit.sv
// act_quant_unit: two-stage per-lane requantize and activation between MMU and controller
module act_quant_unit
    import npu_act_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int MATRIX_SIZE = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [MATRIX_SIZE*ACC_WIDTH-1:0]  in_data,
    input  logic                              in_valid,
    input  logic [1:0]                        act_mode,
    input  logic [SHIFT_WIDTH-1:0]            shift,
    input  logic [DATA_WIDTH-1:0]             clip_max,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] act_output_data,
    output logic                              act_output_valid,
    output logic [MATRIX_SIZE-1:0]            sat_mask,
    output logic [SAT_CNT_WIDTH-1:0]          sat_count
);
    logic ld1, v1_d, v1_q, v2_d, v2_q;
    act_mode_e mode_d, mode_q;
    logic [DATA_WIDTH-1:0] clip_d, clip_q;
    logic [SAT_CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic [MATRIX_SIZE-1:0] sat_nx;

    // config travels with the vector so later changes cannot touch it
    always_comb begin
        ld1    = in_valid & ~clear;
        v1_d   = ld1;
        v2_d   = v1_q & ~clear;
        mode_d = ld1 ? act_mode_e'(act_mode) : mode_q;
        clip_d = ld1 ? clip_max : clip_q;
        cnt_d  = clear ? '0 : (v2_d && |sat_nx && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            mode_q <= ACT_SAT;
            clip_q <= '0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            mode_q <= mode_d;
            clip_q <= clip_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
        act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SHIFT_WIDTH(SHIFT_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (clear),
            .ld1_i  (ld1),
            .ld2_i  (v1_q),
            .x_i    (in_data[k*ACC_WIDTH +: ACC_WIDTH]),
            .shift_i(shift),
            .mode_i (mode_q),
            .clip_i (clip_q),
            .y_o    (act_output_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .sat_o  (sat_mask[k]),
            .sat_d_o(sat_nx[k])
        );
    end

    assign act_output_valid = v2_q;
    assign sat_count        = cnt_q;
endmodule

// File: tb/tb_act_quant_unit.sv
// tb_act_quant_unit: directed vector table plus hand-written streaming, clear and reset sequences
module tb_act_quant_unit;
    import npu_act_pkg::*;
    localparam int DW = 16, AW = 32, MS = 8, SW = 5, NV = 10;

    typedef struct {
        logic [1:0]           mode;
        logic [SW-1:0]        sh;
        logic [DW-1:0]        clip;
        logic [MS-1:0][AW-1:0] x;
        logic [MS-1:0][DW-1:0] y;
        logic [MS-1:0]        m;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0;
    logic [MS*AW-1:0] in_data = '0;
    logic [1:0] act_mode = '0;
    logic [SW-1:0] shift = '0;
    logic [DW-1:0] clip_max = '0;
    logic [MS*DW-1:0] act_output_data;
    logic act_output_valid;
    logic [MS-1:0] sat_mask;
    logic [15:0] sat_count;

    act_quant_unit #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MATRIX_SIZE(MS), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .act_mode(act_mode), .shift(shift), .clip_max(clip_max), .act_output_data(act_output_data),
        .act_output_valid(act_output_valid), .sat_mask(sat_mask), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, exp_cnt = 0;
    vec_t tv[NV];
    vec_t sv[3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] md, input int sh, input int clip,
                                input int x0, input int x1, input int x2, input int x3,
                                input int y0, input int y1, input int y2, input int y3,
                                input logic [MS-1:0] m);
        vec_t v;
        v.mode = md; v.sh = SW'(sh); v.clip = DW'(clip); v.m = m;
        v.x = '0; v.y = '0;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.y[0] = DW'(y0); v.y[1] = DW'(y1); v.y[2] = DW'(y2); v.y[3] = DW'(y3);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_data = v.x; act_mode = v.mode; shift = v.sh; clip_max = v.clip; in_valid = 1'b1;
    endtask

    initial begin
        tv[0] = mk(ACT_SAT,   4, 0,     40, 24, -24, -40,   3, 2, -1, -2,       8'h00);
        tv[1] = mk(ACT_RELU,  0, 0,     -17, 100, 0, 0,     0, 100, 0, 0,       8'h00);
        tv[2] = mk(ACT_LEAKY, 0, 0,     -17, 100, 0, 0,     -3, 100, 0, 0,      8'h00);
        tv[3] = mk(ACT_CLAMP, 0, 64,    500, -5, 70, 0,     64, 0, 64, 0,       8'h00);
        tv[4] = mk(ACT_CLAMP, 0, -1,    500, -5, 70, 0,     0, 0, 0, 0,         8'h00);
        tv[5] = mk(ACT_SAT,   1, 0,     -3, 3, -1, 1,       -1, 2, 0, 1,        8'h00);
        tv[6] = mk(ACT_SAT,   31, 0,    int'(32'h8000_0000), 32'h7FFF_FFFF, 0, -1, -1, 1, 0, 0, 8'h00);
        tv[7] = mk(ACT_LEAKY, 0, 0,     -1000000, 1000000, 0, 0, -32768, 32767, 0, 0, 8'h03);
        tv[8] = mk(ACT_CLAMP, 0, 32767, 100000, -100000, 0, 0,   32767, 0, 0, 0,  8'h00);
        tv[9] = mk(ACT_SAT,   0, 0,     65536, -70000, 0, 0, 32767, -32768, 0, 0, 8'h03);
        sv[0] = mk(ACT_SAT,   0, 0,     -5, 7, 0, 0,        -5, 7, 0, 0,        8'h00);
        sv[1] = mk(ACT_RELU,  0, 0,     -6, 8, 0, 0,        0, 8, 0, 0,         8'h00);
        sv[2] = mk(ACT_SAT,   0, 0,     -7, 9, 0, 0,        -7, 9, 0, 0,        8'h00);

        repeat (2) @(negedge clk);
        chk("reset_valid", act_output_valid, 0);
        chk("reset_data", act_output_data, 0);
        chk("reset_mask", sat_mask, 0);
        chk("reset_count", sat_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i]);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_early", i), act_output_valid, 0);
            @(negedge clk);
            if (tv[i].m != 0) exp_cnt++;
            chk($sformatf("v%0d_valid", i), act_output_valid, 1);
            chk($sformatf("v%0d_data", i), act_output_data, tv[i].y);
            chk($sformatf("v%0d_mask", i), sat_mask, tv[i].m);
            chk($sformatf("v%0d_count", i), sat_count, 16'(exp_cnt));
        end

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", i), act_output_valid, 0);
            chk($sformatf("hold%0d_data", i), act_output_data, tv[NV-1].y);
            chk($sformatf("hold%0d_mask", i), sat_mask, tv[NV-1].m);
        end

        // back-to-back vectors, mode switching every cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 4) begin
                chk($sformatf("stream%0d_valid", i-2), act_output_valid, 1);
                chk($sformatf("stream%0d_data", i-2), act_output_data, sv[i-2].y);
            end else chk($sformatf("stream_idle%0d", i), act_output_valid, 0);
            if (i < 3) drive(sv[i]); else in_valid = 1'b0;
        end

        // clear one cycle behind the input kills the vector and zeroes outputs
        @(negedge clk);
        drive(tv[9]);
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr1_valid", act_output_valid, 0);
        chk("clr1_data", act_output_data, 0);
        chk("clr1_mask", sat_mask, 0);
        chk("clr1_count", sat_count, 0);
        @(negedge clk);
        chk("clr1_valid2", act_output_valid, 0);

        @(negedge clk);
        drive(tv[0]); clear = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("clr2_valid%0d", i), act_output_valid, 0);
            chk($sformatf("clr2_data%0d", i), act_output_data, 0);
        end

        // async reset with a result held and another vector in flight
        @(negedge clk);
        drive(tv[9]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_data", act_output_data, tv[9].y);
        chk("pre_rst_count", sat_count, 1);
        drive(tv[0]);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", act_output_valid, 0);
        chk("rst_data", act_output_data, 0);
        chk("rst_mask", sat_mask, 0);
        chk("rst_count", sat_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid%0d", i), act_output_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
